acc_quant_out: RTL and testbench
================================

Name: acc_quant_out

Overview:
- Downstream stage of the CIM column accumulator.
- Captures the signed 36-bit accumulated sum at the end of each accumulation window, then rounds, shifts, optionally applies ReLU and saturates it to a narrow signed word.
- Buffers results in a small FIFO and presents them to the readout/writeback path over a valid/ready handshake.

Parameters:
- ACC_W, 36, accumulator sum width, signed two's complement
- OUT_W, 8, quantized output width, signed
- DEPTH, 4, output FIFO depth, power of two, ≥2

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- acc_in  in  ACC_W  accumulator sum output
- acc_last  in  1  acc_in holds the final sum of the window this cycle (one-cycle pulse)
- shift  in  5  right-shift amount (0..31), sampled with acc_last
- relu_en  in  1  clamp negatives to 0, sampled with acc_last
- q_data  out  OUT_W  FIFO head result
- q_valid  out  1  FIFO non-empty
- q_ready  in  1  consumer accepts q_data when q_valid&&q_ready
- ovf_flag  out  1  sticky: a result was dropped because the FIFO was full
- sat_flag  out  1  sticky: a result was saturated
- clr_flags  in  1  synchronous clear of ovf_flag/sat_flag

Behaviour:
- Reset, asynchronous while rst=1: pipeline valids=0, FIFO empty (rd/wr ptr=0, count=0), q_valid=0, q_data=0, ovf_flag=0, sat_flag=0. Reset mid-operation discards all in-flight and buffered results.
- S1, edge where acc_last=1:
  - Register r1 = sext(acc_in) + (shift>0 ? 1<<(shift-1) : 0), 37-bit signed, so rounding is half-up and never wraps.
  - Register shift and relu_en with r1; v1=1.
- S2, edge where v1=1:
  - t = r1 >>> shift (arithmetic).
  - If relu_en and t<0, t=0.
  - Saturate t to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; set sat_flag if clamping occurred (ReLU alone does not set it).
  - Register r2; v2=1.
- FIFO push on edge where v2=1:
  - If count<DEPTH, or a pop happens on the same edge, write r2 at wr_ptr.
  - Otherwise drop r2 and set ovf_flag.
- Latency: acc_last at edge E0 → result in FIFO after E2; q_valid=1 in the cycle following E2 if the FIFO was empty.
- Pop on edge where q_valid&&q_ready; q_data is mem[rd_ptr] (combinational from FIFO storage), stable while q_valid&&!q_ready.
- Simultaneous push+pop: count unchanged, both ptrs advance. Full case is legal; the push is accepted.
- Pointers wrap modulo DEPTH. count is kept log2(DEPTH)+1 bits wide.
- acc_last on consecutive cycles is legal: full throughput, one result per cycle.
- q_ready while empty has no effect.
- clr_flags with a new flag event on the same edge: the set wins.
- Pipeline has no stall; backpressure only manifests as ovf drops. Upstream control must bound windows accordingly.

Decomposition:
- Shared package holds:
  - ACC_W and OUT_W defaults
  - SHIFT_W=5
  - saturation bounds as functions of OUT_W
- Sub-module sync_fifo:
  - Parameterised WIDTH/DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Reused by other readout paths.
- Round/shift/saturate stays inline in the top level.

Test Plan:
- acc_in=100, shift=2, relu_en=0, acc_last pulse, q_ready=1 → q_valid rises 3 cycles later with q_data=0x19 (25); flags stay 0.
- acc_in=-100 (0xFFFFFFF9C), shift=2 → q_data=0xE7 (-25); same input with relu_en=1 → q_data=0x00, sat_flag=0.
- Saturation limits:
  - acc_in=1000, shift=0 → q_data=0x7F, sat_flag=1.
  - acc_in=-1000 → q_data=0x80.
  - clr_flags → sat_flag=0.
- Overflow: q_ready=0, five back-to-back acc_last with values 1..5, shift=0 → FIFO holds 1,2,3,4, ovf_flag=1; then q_ready=1 drains 1,2,3,4 in order, q_valid falls.
- FIFO full plus a push and pop on the same edge (q_ready=1 during the 5th push) → no drop, ovf_flag=0, all five results appear in order.
- rst pulsed asynchronously (mid-cycle) with 2 results buffered and 1 in flight → q_valid=0 immediately, flags 0, no stale result emerges afterward; next window produces a correct result.

Source files
------------

// File: rtl/acc_quant_out_pkg.sv
// Shared widths and saturation bounds for the CIM accumulator quantizer and
// the other readout paths.
package acc_quant_out_pkg;

    localparam int ACC_W_DEF = 36;
    localparam int OUT_W_DEF = 8;
    localparam int SHIFT_W   = 5;

    // Largest value representable in a signed out_w-bit word.
    function automatic longint sat_hi(input int out_w);
        return (longint'(1) <<< (out_w - 1)) - 1;
    endfunction

    // Smallest value representable in a signed out_w-bit word.
    function automatic longint sat_lo(input int out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head. A push into a full FIFO is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    // Storage is reset too so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/acc_quant_out.sv
// Captures the window sum, rounds half-up, shifts, optionally clamps
// negatives, saturates to OUT_W and queues the result for readout.
module acc_quant_out
    import acc_quant_out_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ACC_W-1:0]   acc_in,
    input  logic               acc_last,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               relu_en,
    output logic [OUT_W-1:0]   q_data,
    output logic               q_valid,
    input  logic               q_ready,
    output logic               ovf_flag,
    output logic               sat_flag,
    input  logic               clr_flags
);

    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W + 1)'(sat_hi(OUT_W));
    localparam logic signed [ACC_W:0] SAT_LO = (ACC_W + 1)'(sat_lo(OUT_W));

    logic signed [ACC_W:0] r1_d, r1_q, rnd, t;
    logic [SHIFT_W-1:0]    sh1_q;
    logic                  relu1_q, v1_q;
    logic [OUT_W-1:0]      r2_d, r2_q;
    logic                  v2_q;
    logic                  clamp, sat_evt, ovf_evt;
    logic                  sat_d, sat_q, ovf_d, ovf_q;
    logic                  fifo_full, fifo_empty;

    // One extra bit of headroom so adding the rounding constant never wraps.
    always_comb begin
        rnd  = '0;
        if (shift != '0) rnd = {{ACC_W{1'b0}}, 1'b1} << (shift - 1'b1);
        r1_d = {acc_in[ACC_W-1], acc_in} + rnd;
    end

    always_comb begin
        clamp = 1'b0;
        t     = r1_q >>> sh1_q;
        if (relu1_q && t[ACC_W]) t = '0;
        if (t > SAT_HI) begin
            t     = SAT_HI;
            clamp = 1'b1;
        end else if (t < SAT_LO) begin
            t     = SAT_LO;
            clamp = 1'b1;
        end
        r2_d = t[OUT_W-1:0];
    end

    // Full FIFO pops only when the consumer is ready, so no pop means a drop.
    assign sat_evt = v1_q && clamp;
    assign ovf_evt = v2_q && fifo_full && !q_ready;
    assign sat_d   = (sat_q && !clr_flags) || sat_evt;
    assign ovf_d   = (ovf_q && !clr_flags) || ovf_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_q    <= '0;
            sh1_q   <= '0;
            relu1_q <= 1'b0;
            v1_q    <= 1'b0;
            r2_q    <= '0;
            v2_q    <= 1'b0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            v1_q  <= acc_last;
            v2_q  <= v1_q;
            sat_q <= sat_d;
            ovf_q <= ovf_d;
            if (acc_last) begin
                r1_q    <= r1_d;
                sh1_q   <= shift;
                relu1_q <= relu_en;
            end
            if (v1_q) r2_q <= r2_d;
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (v2_q),
        .pop   (q_ready),
        .din   (r2_q),
        .dout  (q_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign q_valid  = !fifo_empty;
    assign sat_flag = sat_q;
    assign ovf_flag = ovf_q;

endmodule

// File: tb/tb_acc_quant_out.sv
// Bench for acc_quant_out: directed scenarios plus random traffic, checked
// against an arithmetic quantizer and a queue-based FIFO occupancy model.
module tb_acc_quant_out;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [35:0] acc_in = '0;
    logic        acc_last = 1'b0;
    logic [4:0]  shift = '0;
    logic        relu_en = 1'b0;
    logic [7:0]  q_data;
    logic        q_valid;
    logic        q_ready = 1'b0;
    logic        ovf_flag;
    logic        sat_flag;
    logic        clr_flags = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    bit         exp_ovf, exp_sat;
    bit         p1_v, p1_c, p2_v, p2_c;
    logic [7:0] p1_d, p2_d;

    always #5 clk = ~clk;

    acc_quant_out dut (
        .clk       (clk),
        .rst       (rst),
        .acc_in    (acc_in),
        .acc_last  (acc_last),
        .shift     (shift),
        .relu_en   (relu_en),
        .q_data    (q_data),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .ovf_flag  (ovf_flag),
        .sat_flag  (sat_flag),
        .clr_flags (clr_flags)
    );

    // Round half-up, arithmetic shift, optional ReLU, saturate to int8.
    function automatic void quant(input logic [35:0] a, input int sh, input bit relu,
                                  output logic [7:0] q, output bit c);
        longint v, t;
        v = longint'($signed(a));
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        t = v >>> sh;
        if (relu && t < 0) t = 0;
        c = 1'b0;
        if (t > 127) begin
            t = 127;
            c = 1'b1;
        end else if (t < -128) begin
            t = -128;
            c = 1'b1;
        end
        q = t[7:0];
    endfunction

    task automatic model_clear();
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_sat = 1'b0;
        p1_v = 1'b0;
        p2_v = 1'b0;
    endtask

    // One clock: drive, check outputs mid-cycle, advance model over the edge.
    task automatic step(input logic last, input logic [35:0] a, input logic [4:0] sh,
                        input logic relu, input logic rdy, input logic clr);
        bit do_pop, accept, ovf_evt, sat_evt;
        acc_last = last; acc_in = a; shift = sh; relu_en = relu;
        q_ready = rdy; clr_flags = clr;
        #3;
        n_vec++;
        if (q_valid !== (exp_q.size() > 0)) begin
            n_err++;
            $display("FAIL q_valid t=%0t got=%b want=%b", $time, q_valid, exp_q.size() > 0);
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            if (q_data !== exp_q[0]) begin
                n_err++;
                $display("FAIL q_data t=%0t got=%h want=%h", $time, q_data, exp_q[0]);
            end
        end
        n_vec++;
        if (ovf_flag !== exp_ovf) begin
            n_err++;
            $display("FAIL ovf_flag t=%0t got=%b want=%b", $time, ovf_flag, exp_ovf);
        end
        n_vec++;
        if (sat_flag !== exp_sat) begin
            n_err++;
            $display("FAIL sat_flag t=%0t got=%b want=%b", $time, sat_flag, exp_sat);
        end
        do_pop  = (exp_q.size() > 0) && rdy;
        accept  = p2_v && ((exp_q.size() < DEPTH) || do_pop);
        ovf_evt = p2_v && !accept;
        sat_evt = p1_v && p1_c;
        exp_ovf = (exp_ovf && !clr) || ovf_evt;
        exp_sat = (exp_sat && !clr) || sat_evt;
        if (do_pop) void'(exp_q.pop_front());
        if (accept) exp_q.push_back(p2_d);
        p2_v = p1_v; p2_d = p1_d; p2_c = p1_c;
        p1_v = last;
        if (last) quant(a, int'(sh), relu, p1_d, p1_c);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, rdy, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_vec += 4;
        if (q_valid !== 1'b0) begin n_err++; $display("FAIL reset_q_valid got=%b want=0", q_valid); end
        if (q_data !== 8'h00) begin n_err++; $display("FAIL reset_q_data got=%h want=00", q_data); end
        if (ovf_flag !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b want=0", ovf_flag); end
        if (sat_flag !== 1'b0) begin n_err++; $display("FAIL reset_sat got=%b want=0", sat_flag); end
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        step(1'b1, 36'd100, 5'd2, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);
        step(1'b1, -36'sd100, 5'd2, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);
        step(1'b1, -36'sd100, 5'd2, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);
    endtask

    task automatic test_saturate();
        step(1'b1, 36'd1000, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, -36'sd1000, 5'd0, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) step(1'b1, 36'(i), 5'd0, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        idle(7, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);
    endtask

    // Fifth result is pushed at the sixth edge after the first acc_last.
    task automatic test_back_to_back();
        for (int i = 1; i <= 5; i++) step(1'b1, 36'(i * 3), 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        idle(8, 1'b1);
    endtask

    task automatic test_reset_midflight();
        step(1'b1, 36'd1000, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 36'd20, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 36'd30, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_vec += 3;
        if (q_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_q_valid got=%b want=0", q_valid); end
        if (sat_flag !== 1'b0) begin n_err++; $display("FAIL async_rst_sat got=%b want=0", sat_flag); end
        if (ovf_flag !== 1'b0) begin n_err++; $display("FAIL async_rst_ovf got=%b want=0", ovf_flag); end
        model_clear();
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(5, 1'b1);
        step(1'b1, 36'd77, 5'd1, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);
    endtask

    task automatic test_random();
        logic [63:0] r;
        logic [35:0] a;
        for (int i = 0; i < 400; i++) begin
            r = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) a = 36'($urandom_range(0, 4000)) - 36'd2000;
            else a = r[35:0];
            step(1'($urandom_range(0, 1)), a, 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 19) == 0));
        end
        idle(8, 1'b1);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_saturate();
        test_overflow();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
